// File: rtl/kv_csa_resolve_pkg.sv
// kv_csa_pkg: shared state encoding and chunk-count helper for the carry-save resolver
package kv_csa_pkg;
  typedef enum logic [1:0] {
    KV_CSA_IDLE = 2'd0,
    KV_CSA_BUSY = 2'd1,
    KV_CSA_DONE = 2'd2
  } kv_csa_state_e;
  function automatic int kv_csa_nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction
endpackage

// File: rtl/kv_csa_resolve_if.sv
// kv_csa_resolve_if: operand/result handshake bundle between the CSA tree and normalisation
interface kv_csa_resolve_if #(parameter int CSA_WIDTH = 32);
  localparam int OUT_W = CSA_WIDTH + 2;
  logic                 in_valid;
  logic                 in_ready;
  logic [CSA_WIDTH:0]   in_sum;
  logic [CSA_WIDTH-1:0] in_carry;
  logic                 kill;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_result;
  logic                 out_ovf;
  modport master (
    output in_valid, in_sum, in_carry, kill, out_ready,
    input  in_ready, out_valid, out_result, out_ovf
  );
  modport slave (
    input  in_valid, in_sum, in_carry, kill, out_ready,
    output in_ready, out_valid, out_result, out_ovf
  );
endinterface

// File: rtl/kv_csa_resolve_cpa_slice.sv
// kv_cpa_slice: one CHUNK-bit ripple add, the only carry path a resolver cycle sees
module kv_cpa_slice #(parameter int CHUNK = 8) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/kv_csa_resolve.sv
// kv_csa_resolve: chunked multi-cycle carry-propagate add turning a sum/carry pair into binary
module kv_csa_resolve
  import kv_csa_pkg::*;
#(
  parameter int CSA_WIDTH = 32,
  parameter int CHUNK     = 8
) (
  input logic               clk,
  input logic               resetn,
  kv_csa_resolve_if.slave   bus
);
  localparam int OUT_W  = CSA_WIDTH + 2;
  localparam int NCHUNK = kv_csa_nchunk(OUT_W, CHUNK);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  kv_csa_state_e    state_q;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;
  logic [PW-1:0]    a_q, b_q, acc_q, acc_d;
  logic [OUT_W-1:0] res_q;
  logic             ovf_q;
  logic [CHUNK-1:0] s;
  logic             cout;
  logic [PW:0]      ext;
  logic             accept, last;
  assign accept = (state_q == KV_CSA_IDLE) && bus.in_valid && !bus.kill;
  assign last   = (cnt_q == CW'(NCHUNK - 1));
  kv_cpa_slice #(.CHUNK(CHUNK)) u_slice (
    .a   (a_q[cnt_q*CHUNK +: CHUNK]),
    .b   (b_q[cnt_q*CHUNK +: CHUNK]),
    .cin (cy_q),
    .s   (s),
    .cout(cout)
  );
  // Splice the freshly resolved chunk into the working sum; the top carry rides above it
  always_comb begin
    acc_d = acc_q;
    acc_d[cnt_q*CHUNK +: CHUNK] = s;
    ext = {cout, acc_d};
  end
  // Operand capture at accept and working-sum update while busy; no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= PW'(bus.in_sum);
      b_q <= PW'({bus.in_carry, 1'b0});
    end
    if (state_q == KV_CSA_BUSY) acc_q <= acc_d;
  end
  // Control FSM; the delivered result only moves on entry to DONE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= KV_CSA_IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        KV_CSA_IDLE: if (accept) begin
          state_q <= KV_CSA_BUSY;
          cnt_q   <= '0;
          cy_q    <= 1'b0;
        end
        KV_CSA_BUSY: if (bus.kill) state_q <= KV_CSA_IDLE;
        else begin
          cy_q  <= cout;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q <= KV_CSA_DONE;
            res_q   <= acc_d[OUT_W-1:0];
            ovf_q   <= |ext[PW:OUT_W];
          end
        end
        KV_CSA_DONE: if (bus.kill || bus.out_ready) state_q <= KV_CSA_IDLE;
        default: state_q <= KV_CSA_IDLE;
      endcase
    end
  end
  assign bus.in_ready   = (state_q == KV_CSA_IDLE);
  assign bus.out_valid  = (state_q == KV_CSA_DONE);
  assign bus.out_result = res_q;
  assign bus.out_ovf    = ovf_q;
endmodule

// File: doc/kv_csa_resolve.md
Name: kv_csa_resolve

Overview:
- Converts the carry-save pair produced by the team's 4:2 compressors into a plain binary result: result = sum + (carry << 1).
- Resolves the pair with a multi-cycle, chunked carry-propagate adder. Each cycle handles CHUNK bits, so the critical path is one CHUNK-bit add.
- Sits between the CSA tree of the f16 MAC datapath and normalisation/rounding. Uses a valid/ready handshake on both sides.

Parameters:
- CSA_WIDTH, 32: width of each compressor input operand. sum is CSA_WIDTH+1 bits, carry is CSA_WIDTH bits.
- CHUNK, 8: bits resolved per cycle; range 1..CSA_WIDTH+2.
- Derived, not overridable: OUT_W = CSA_WIDTH+2; NCHUNK = ceil(OUT_W/CHUNK) (5 at defaults).

Ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_sum  in  CSA_WIDTH+1  compressor sum vector.
- in_carry  in  CSA_WIDTH  compressor carry vector (weight 2, i.e. shifted left by one).
- kill  in  1  synchronous abort of the operation in flight.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  OUT_W  resolved binary value, modulo 2^OUT_W.
- out_ovf  out  1  carry out of bit OUT_W-1. Always 0 for legal 4:2 outputs; this is a diagnostic.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, in_ready=1 once state is IDLE, out_valid=0, out_result=0, out_ovf=0, chunk counter=0, carry flop=0. Internal operand registers have no reset requirement.
- States: IDLE, BUSY, DONE (2-bit encoding).
- in_ready = (state==IDLE). It is a registered-state decode and never depends combinationally on in_valid.
- out_valid = (state==DONE).
- IDLE -> BUSY on in_valid & in_ready:
  - latch A = zero-extend(in_sum) and B = zero-extend({in_carry,1'b0}) to NCHUNK*CHUNK bits;
  - clear counter and carry flop.
- BUSY, each cycle:
  - add chunk[cnt] of A and B plus the carry flop;
  - write that chunk of the result register, update the carry flop, increment cnt.
  - When cnt==NCHUNK-1 this cycle, go to DONE. Bits at or above OUT_W are discarded.
  - out_ovf = bit OUT_W of the padded sum if NCHUNK*CHUNK > OUT_W, otherwise the final carry flop.
- Latency: handshake in cycle T gives out_valid high in cycle T+NCHUNK+1 (first visible after NCHUNK BUSY edges).
- DONE: out_result and out_ovf stay stable while out_valid=1 & out_ready=0. On out_ready, go to IDLE. There is no same-cycle re-accept, so the minimum issue interval is NCHUNK+2 cycles.
- out_result changes only on the transition into DONE. During BUSY it shows the previous result.
- kill in BUSY or DONE: go to IDLE next edge, out_valid drops, result not delivered; out_result keeps its last delivered value.
- kill in IDLE: ignored. A kill coinciding with in_valid in IDLE blocks the accept; kill has priority.
- kill in DONE together with out_ready: this counts as a kill, although both lead to IDLE.
- Reset mid-operation: immediate return to reset values. No partial result is ever marked valid.
- in_sum and in_carry are sampled only at the accept edge; later changes have no effect.
- CHUNK not dividing OUT_W: the last chunk is partial via zero padding and the latency is still NCHUNK.

Decomposition:
- Shared package kv_csa_pkg holds:
  - state encoding constants KV_CSA_IDLE=2'd0, KV_CSA_BUSY=2'd1, KV_CSA_DONE=2'd2;
  - a constant function kv_csa_nchunk(width, chunk) returning ceil(width/chunk).
- One sub-module, kv_cpa_slice:
  - parameter CHUNK; inputs a[CHUNK], b[CHUNK], cin;
  - outputs s[CHUNK], cout; purely combinational.
- The top holds the FSM, counter, operand/result registers and chunk muxing.

Test Plan (defaults, CSA_WIDTH=32, CHUNK=8):
- Full ripple: in_sum=0x0_FFFF_FFFF, in_carry=0x0000_0001 -> out_result=0x1_0000_0001, out_ovf=0, out_valid exactly 6 cycles after the accept cycle.
- Top bits: in_sum=0x1_0000_0000, in_carry=0xFFFF_FFFF -> out_result=0x2_FFFF_FFFE, out_ovf=0.
- Backpressure: after DONE, hold out_ready=0 for 3 cycles -> out_valid stays 1, out_result stable, in_ready=0, a pending in_valid is not accepted. Then raise out_ready -> IDLE next cycle, in_ready=1.
- Kill: accept in_sum=0x1_2345_6789, in_carry=0x1111_1111, assert kill in the 3rd BUSY cycle -> IDLE next cycle, out_valid never rises, out_result keeps its previous value.
- Reset mid-op: drop resetn in BUSY -> all outputs return to reset values immediately. Then accept in_sum=0, in_carry=0 -> out_result=0 after 6 cycles.
- Back-to-back: two pairs with out_ready tied high -> the second accept occurs exactly one cycle after the first result handshake; both results correct.
